// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int WAIT_W = 4;

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the CPU memory port and the responder.
// The be lanes exist only when MEM_RESP_BYTE_MASK_EN is defined.
interface mem_responder_if import mem_resp_pkg::*; #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
`ifdef MEM_RESP_BYTE_MASK_EN
  logic [lanes(DATA_W)-1:0] be;
`endif
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

`ifdef MEM_RESP_BYTE_MASK_EN
  modport master (output req, we, addr, wdata, be, input ack, rdata, busy);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata, busy);
`else
  modport master (output req, we, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
`endif
endinterface

// File: rtl/mem_resp_array.sv
// Word-addressed storage: one write port, one registered read port, no reset.
// Per-lane write enables when MEM_RESP_BYTE_MASK_EN is defined.
module mem_resp_array import mem_resp_pkg::*; #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
`ifdef MEM_RESP_BYTE_MASK_EN
  input  logic [lanes(DATA_W)-1:0] be,
`endif
  output logic [DATA_W-1:0]        rdata
);
  localparam int LANES = lanes(DATA_W);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
`ifdef MEM_RESP_BYTE_MASK_EN
    for (int i = 0; i < LANES; i++)
      if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
`else
    if (we) mem[addr] <= wdata;
`endif
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory slave: capture request, count WAIT_CYCLES, access, pulse ack.
// Optional byte-lane write masking via MEM_RESP_BYTE_MASK_EN.
module mem_responder import mem_resp_pkg::*; #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);
  localparam int LANES = lanes(DATA_W);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
`ifdef MEM_RESP_BYTE_MASK_EN
    logic [LANES-1:0]  be;
`endif
  } req_t;

  state_t            state, nxt;
  logic [WAIT_W-1:0] cnt;
  req_t              cap;
  logic              ack_q, busy_q, rd_seen, done;
  logic [DATA_W-1:0] arr_rdata;

  assign done = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.req) nxt = WAIT;
      WAIT:    if (cnt == '0) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cap     <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      ack_q  <= done;
      busy_q <= (nxt != IDLE);
      if (state == IDLE && bus.req) begin
        cap.we    <= bus.we;
        cap.addr  <= bus.addr;
        cap.wdata <= bus.wdata;
`ifdef MEM_RESP_BYTE_MASK_EN
        cap.be    <= bus.be;
`endif
        cnt       <= WAIT_W'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done && !cap.we) rd_seen <= 1'b1;
    end
  end

  // The array's read register has no reset; rd_seen masks it to zero until
  // the first read completes (and again after any reset).
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rd_seen ? arr_rdata : '0;

  mem_resp_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk   (clk),
    .we    (done && cap.we),
    .re    (done && !cap.we),
    .addr  (cap.addr),
    .wdata (cap.wdata),
`ifdef MEM_RESP_BYTE_MASK_EN
    .be    (cap.be),
`endif
    .rdata (arr_rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Directed checks of mem_responder with WAIT_CYCLES=2 (u2) and WAIT_CYCLES=0 (u0).
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] rd;
  logic        ok;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(6), .DATA_W(32)) b2 ();
  mem_responder_if #(.ADDR_W(6), .DATA_W(32)) b0 ();

  mem_responder #(.ADDR_W(6), .DATA_W(32), .WAIT_CYCLES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  mem_responder #(.ADDR_W(6), .DATA_W(32), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack2(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc;
      if (b2.ack) begin seen = 1'b1; break; end
    end
  endtask

  task automatic wait_ack0(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc;
      if (b0.ack) begin seen = 1'b1; break; end
    end
  endtask

  // One full transaction on u2; returns rdata sampled in the ack cycle.
  task automatic do2(input string tag, input logic w, input logic [5:0] a,
                     input logic [31:0] d, input logic [3:0] m, output logic [31:0] r);
    logic seen;
    b2.we = w; b2.addr = a; b2.wdata = d; b2.req = 1'b1;
`ifdef MEM_RESP_BYTE_MASK_EN
    b2.be = m;
`else
    if (m == 4'h0) b2.wdata = d;
`endif
    cyc;
    b2.req = 1'b0;
    wait_ack2(seen);
    r = b2.rdata;
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    cyc;
  endtask

  initial begin
    rst_n = 1'b0;
    b2.req = 0; b2.we = 0; b2.addr = 0; b2.wdata = 0;
    b0.req = 0; b0.we = 0; b0.addr = 0; b0.wdata = 0;
`ifdef MEM_RESP_BYTE_MASK_EN
    b2.be = 4'hF; b0.be = 4'hF;
`endif
    #12;
    chk("rst_ack",   {31'd0, b2.ack},  32'd0);
    chk("rst_busy",  {31'd0, b2.busy}, 32'd0);
    chk("rst_rdata", b2.rdata,         32'd0);
    cyc; cyc;
    rst_n = 1'b1;

    // write addr 5, exact cycle timing
    b2.we = 1; b2.addr = 5; b2.wdata = 32'hDEADBEEF; b2.req = 1;
    cyc; b2.req = 0;
    chk("w_e1_busy", {31'd0, b2.busy}, 32'd1);
    chk("w_e1_ack",  {31'd0, b2.ack},  32'd0);
    cyc; chk("w_e2_ack", {31'd0, b2.ack}, 32'd0);
    cyc; chk("w_e3_ack", {31'd0, b2.ack}, 32'd0);
    chk("w_e3_busy", {31'd0, b2.busy}, 32'd1);
    cyc; chk("w_e4_ack", {31'd0, b2.ack}, 32'd1);
    chk("w_e4_busy", {31'd0, b2.busy}, 32'd1);
    chk("w_e4_rdata", b2.rdata, 32'd0);
    cyc; chk("w_e5_ack", {31'd0, b2.ack}, 32'd0);
    chk("w_e5_busy", {31'd0, b2.busy}, 32'd0);

    // read back, then hold
    do2("rd5", 0, 5, 0, 4'hF, rd);
    chk("rd5_ack_data", rd, 32'hDEADBEEF);
    cyc; cyc;
    chk("rd5_held", b2.rdata, 32'hDEADBEEF);
    do2("wr6", 1, 6, 32'h66666666, 4'hF, rd);
    chk("rdata_after_wr", b2.rdata, 32'hDEADBEEF);

    // inputs changed during WAIT must not affect the read in flight
    b2.we = 0; b2.addr = 5; b2.req = 1;
    cyc; b2.req = 0; b2.addr = 6; b2.we = 1; b2.wdata = 32'h00000BAD;
    wait_ack2(ok);
    chk("chg_ack_seen", {31'd0, ok}, 32'd1);
    chk("chg_rdata", b2.rdata, 32'hDEADBEEF);
    cyc;
    do2("rd6", 0, 6, 0, 4'hF, rd);
    chk("rd6_unchanged", rd, 32'h66666666);

    // reset during WAIT of a write aborts it
    do2("wr9", 1, 9, 32'h0BADF00D, 4'hF, rd);
    do2("rd9a", 0, 9, 0, 4'hF, rd);
    chk("rd9_old", rd, 32'h0BADF00D);
    b2.we = 1; b2.addr = 9; b2.wdata = 32'h12345678; b2.req = 1;
    cyc; b2.req = 0;
    cyc;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack",   {31'd0, b2.ack},  32'd0);
    chk("midrst_rdata", b2.rdata,         32'd0);
    chk("midrst_busy",  {31'd0, b2.busy}, 32'd0);
    cyc; rst_n = 1'b1;
    cyc; cyc; cyc;
    do2("rd9b", 0, 9, 0, 4'hF, rd);
    chk("rd9_after_abort", rd, 32'h0BADF00D);

    // WAIT_CYCLES=0: seed addr 0, then back-to-back reads with req held
    b0.we = 1; b0.addr = 0; b0.wdata = 32'hA5A50000; b0.req = 1;
    cyc; b0.req = 0;
    wait_ack0(ok);
    chk("u0_wr_ack_seen", {31'd0, ok}, 32'd1);
    cyc;
    b0.we = 0; b0.addr = 0; b0.req = 1;
    cyc; chk("b2b_e1_ack", {31'd0, b0.ack}, 32'd0);
    chk("b2b_e1_busy", {31'd0, b0.busy}, 32'd1);
    cyc; chk("b2b_e2_ack", {31'd0, b0.ack}, 32'd1);
    chk("b2b_e2_rdata", b0.rdata, 32'hA5A50000);
    cyc; chk("b2b_e3_ack", {31'd0, b0.ack}, 32'd0);
    chk("b2b_e3_busy", {31'd0, b0.busy}, 32'd0);
    cyc; chk("b2b_e4_ack", {31'd0, b0.ack}, 32'd0);
    chk("b2b_e4_busy", {31'd0, b0.busy}, 32'd1);
    cyc; chk("b2b_e5_ack", {31'd0, b0.ack}, 32'd1);
    b0.req = 0;
    cyc; chk("b2b_e6_ack", {31'd0, b0.ack}, 32'd0);
    cyc; chk("b2b_e7_ack", {31'd0, b0.ack}, 32'd0);
    chk("b2b_e7_busy", {31'd0, b0.busy}, 32'd0);

`ifdef MEM_RESP_BYTE_MASK_EN
    do2("bm_wr_all", 1, 3, 32'hFFFFFFFF, 4'hF, rd);
    do2("bm_wr_mask", 1, 3, 32'h00000000, 4'b0101, rd);
    do2("bm_rd", 0, 3, 0, 4'h0, rd);
    chk("bm_masked", rd, 32'hFF00FF00);
    do2("bm_wr_none", 1, 3, 32'h12345678, 4'h0, rd);
    do2("bm_rd2", 0, 3, 0, 4'hF, rd);
    chk("bm_noop", rd, 32'hFF00FF00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle memory responder: the slave end of the CPU's instruction/data memory port. It accepts one read or write request at a time over a req/ack handshake, inserts a programmable number of wait states, then completes the access and pulses `ack`. It sits between the multi-cycle CPU datapath's address mux and the word-addressed storage array, replacing the zero-latency memory so the control FSM can be exercised against a slow memory.

## Interface
- `ADDR_W`, 6: word-address width; depth is 2**ADDR_W words.
- `DATA_W`, 32: word width; must be a multiple of 8.
- `WAIT_CYCLES`, 2: wait states inserted per access; legal range 0..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request valid; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; captured with `req`.
- `addr`  in  ADDR_W  word address; captured with `req`.
- `wdata`  in  DATA_W  write data; captured with `req`.
- `be`  in  DATA_W/8  byte-lane write enables; present only with `MEM_RESP_BYTE_MASK_EN`.
- `ack`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  read data; valid while `ack`=1 after a read, held until the next read completes.
- `busy`  out  1  high in WAIT and RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `req`=1 at an edge, capture `we`, `addr`, `wdata` (and `be`) into internal registers, load the wait counter with WAIT_CYCLES, and go to WAIT. Otherwise stay in IDLE.
- WAIT: if counter ≠ 0, decrement it. If counter = 0, perform the access on the captured request, set `ack`=1, and go to RESP.
  - Read: `rdata` ← mem[addr].
  - Write: mem[addr] ← wdata; `rdata` unchanged.
- RESP: clear `ack` and go to IDLE unconditionally. `req` is ignored.
- Input changes after capture have no effect on the transaction in flight.
- Address space is fully decoded (2**ADDR_W words), so no out-of-range case exists. The counter does not wrap.
- Reset (asynchronous, any state): state=IDLE, counter=0, captured registers=0, `ack`=0, `busy`=0, `rdata`=0.
  - A write that has not yet reached its completion edge is aborted; memory is unchanged.
  - The storage array is never reset.

## Timing
- Request sampled at edge k → `ack` high for exactly the cycle following edge k+WAIT_CYCLES+1.
- With WAIT_CYCLES=0, `ack` follows edge k+1.
- `ack` drops at edge k+WAIT_CYCLES+2. The earliest next acceptance is at edge k+WAIT_CYCLES+3, which is one mandatory IDLE cycle.
- If `req` is still high at that edge, a new transaction is accepted. The initiator is responsible for dropping `req` after seeing `ack` when it does not want a repeat.
- Read-after-write to the same address returns the new data.
- `busy` is registered: it rises at edge k and falls at edge k+WAIT_CYCLES+2.

## Configuration
- `MEM_RESP_BYTE_MASK_EN` defined:
  - The `be` port exists and is captured with the request.
  - A write updates only the byte lanes whose `be` bit is 1.
  - A write with `be`=0 is a no-op but still completes with `ack`.
  - Reads ignore `be`.
- Undefined: the `be` port is absent and every write updates the full word.

## Structure
- Package `mem_resp_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - the counter width constant WAIT_W=4;
  - the lane-count helper DATA_W/8.
- Sub-module `mem_resp_array`: synchronous storage array with one write port (per-lane enable when `MEM_RESP_BYTE_MASK_EN` is defined) and one synchronous read port. It has no reset.
- The top level holds the FSM, the wait counter, the capture registers and the output registers.

## Test plan
- Reset, then WAIT_CYCLES=2: write addr=5, wdata=32'hDEADBEEF, req at edge 1.
  - `ack` high only after edge 4.
  - `busy` high from edge 1 to edge 5.
- Read addr=5 after the write → `rdata`=32'hDEADBEEF in the `ack` cycle, held after `ack` drops.
- WAIT_CYCLES=0 with back-to-back `req` held high for a read of addr=0 → acks in the cycles after edges 2 and 5, with exactly one IDLE cycle between them.
- Change `addr` from 5 to 6 during WAIT of a read → `rdata` still returns mem[5].
- Assert `rst_n`=0 mid-WAIT of a write of 32'h12345678 to addr=9 → `ack`=0 and `rdata`=0 immediately; a later read of addr=9 returns the old value.
- With `MEM_RESP_BYTE_MASK_EN`: write 32'hFFFFFFFF to addr=3, then write 32'h00000000 with `be`=4'b0101 → read of addr=3 returns 32'hFF00FF00.
